// File: rtl/tinker_pkg.sv
// Shared types and constants for the Tinker fetch stage.
//   DEFAULT_OP_HALT  : opcode (instr[31:27]) that stops fetching
//   DEFAULT_RESET_PC : fetch PC after reset
//   fetch_state_t    : fetch state machine encoding
//   fetch_entry_t    : {pc, instr} pair held in the instruction queue
package tinker_pkg;

  localparam logic [4:0]  DEFAULT_OP_HALT  = 5'h0F;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_2000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT   = 2'd2,
    HALTED = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // An all-zero word is treated like a halt so fetch stops on uninitialised memory.
  function automatic logic is_halt_word(input logic [31:0] instr, input logic [4:0] op_halt);
    return (instr[31:27] == op_halt) || (instr == 32'h0);
  endfunction

endpackage

// File: rtl/tinker_fetch_fifo.sv
// DEPTH-entry synchronous FIFO of fetch_entry_t.
//   clk, reset : clock, asynchronous active-high reset
//   push/data  : write an entry (caller guarantees space)
//   pop        : drop the head (ignored when empty)
//   flush      : empty the queue; overrides a same-cycle push/pop
//   head       : oldest entry, count/full/empty : occupancy status
module tinker_fetch_fifo
  import tinker_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  input  logic                     flush,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  fetch_entry_t   mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [AW:0]    count_q;
  logic           do_pop;

  assign do_pop = pop & ~empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push)   wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, do_pop};
    end
  end

  // Storage needs no reset: nothing is visible until count is non-zero.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == (AW + 1)'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/tinker_fetch_unit.sv
// Decoupled instruction fetch for the Tinker core.
//   clk, reset                : clock, asynchronous active-high reset
//   redirect_valid/pc         : control redirect (taken branch/jump), highest priority
//   imem_req/addr/gnt         : one-outstanding request handshake to instruction memory
//   imem_rvalid/rdata         : response word
//   out_valid/ready/instr/pc  : {pc, instr} stream to decode
//   halted                    : fetch stopped on a halt word; cleared by redirect
module tinker_fetch_unit
  import tinker_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [4:0]  OP_HALT  = DEFAULT_OP_HALT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        halted
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_t  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   inflight_pc_q, inflight_pc_d;
  logic          discard_q, discard_d;

  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  fetch_entry_t  fifo_head, push_entry;
  logic [CW:0]   occupancy;
  logic          credit_ok;
  logic          unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Queue entries plus the word in flight must stay below DEPTH before a new request.
  assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, (state_q == WAIT)};
  assign credit_ok = (occupancy < (CW + 1)'(DEPTH));

  assign push_entry = '{pc: inflight_pc_q, instr: imem_rdata};
  assign fifo_push  = (state_q == WAIT) & imem_rvalid & ~discard_q & ~redirect_valid &
                      (~fifo_full | fifo_pop);
  assign fifo_pop   = out_valid & out_ready & ~redirect_valid;

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    discard_d     = discard_q;

    unique case (state_q)
      IDLE: begin
        if (credit_ok) state_d = REQ;
      end
      REQ: begin
        if (imem_gnt) begin
          inflight_pc_d = fetch_pc_q;
          fetch_pc_d    = fetch_pc_q + 32'd4;
          state_d       = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          discard_d = 1'b0;
          state_d   = (!discard_q && is_halt_word(imem_rdata, OP_HALT)) ? HALTED : IDLE;
        end
      end
      HALTED: state_d = HALTED;
      default: state_d = IDLE;
    endcase

    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      // A granted request still owes a response: wait it out and drop it.
      if ((state_q == WAIT && !imem_rvalid) || (state_q == REQ && imem_gnt)) begin
        state_d   = WAIT;
        discard_d = 1'b1;
      end else begin
        state_d   = IDLE;
        discard_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= '0;
      discard_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      discard_q     <= discard_d;
    end
  end

  tinker_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .flush     (redirect_valid),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign imem_req  = (state_q == REQ);
  assign imem_addr = imem_req ? fetch_pc_q : 32'h0;
  assign out_valid = ~fifo_empty;
  assign out_instr = out_valid ? fifo_head.instr : 32'h0;
  assign out_pc    = out_valid ? fifo_head.pc : 32'h0;
  assign halted    = (state_q == HALTED);

endmodule

// File: tb/tb_tinker_fetch_unit.sv
// Self-checking bench for tinker_fetch_unit: a directed vector table from reset,
// directed corner sequences, then randomized traffic against a scoreboard.
module tb_tinker_fetch_unit;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        halted;

  tinker_fetch_unit #(
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0000_2000),
    .OP_HALT  (5'h0F)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural memory + scoreboard ----------------
  logic        halt_mode = 1'b0;
  logic [31:0] exp_q[$];          // words the fetch unit must be holding, oldest first
  logic [31:0] exp_addr;          // next address the fetch stream must request
  logic        halted_exp;
  logic        mem_busy = 1'b0;
  logic        mem_stale = 1'b0;  // response belongs to a pre-redirect/pre-reset request
  logic [31:0] mem_pc;
  int          mem_cnt = 0;
  int          gnt_wait = 0;
  int          gnt_lo = 0, gnt_hi = 0, r_lo = 0, r_hi = 0;
  int          ready_mode = 1;    // 0: never ready, 1: always ready, 2: random
  int          n_gnt = 0;
  logic        last_req, last_valid;
  logic [31:0] last_pc;
  logic        got_pop, got_gnt;
  logic [31:0] first_pop_pc, first_gnt_addr;

  function automatic logic [31:0] mem_fn(input logic [31:0] pc);
    if (halt_mode && pc == 32'h2008) return 32'h7800_0000;
    return 32'h8C00_0000 + pc;
  endfunction

  function automatic logic stops_fetch(input logic [31:0] w);
    return (w[31:27] == 5'h0F) || (w == 32'h0);
  endfunction

  task automatic arm();
    got_pop = 1'b0;
    got_gnt = 1'b0;
    first_pop_pc = '0;
    first_gnt_addr = '0;
  endtask

  // One clock: sample at negedge, check, drive the next edge's inputs, advance the model.
  task automatic cycle(input logic redir, input logic [31:0] tgt);
    logic s_req, s_valid, s_halted, rdy, g, rv;
    logic [31:0] s_addr, s_pc, s_instr, word;
    @(negedge clk);
    s_req = imem_req; s_addr = imem_addr; s_valid = out_valid;
    s_pc = out_pc; s_instr = out_instr; s_halted = halted;
    last_req = s_req; last_valid = s_valid; last_pc = s_pc;

    chk("out_valid", s_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      chk("out_pc", s_pc, exp_q[0]);
      chk("out_instr", s_instr, mem_fn(exp_q[0]));
    end
    chk("halted", s_halted, halted_exp);
    if (halted_exp) chk("req_while_halted", s_req, 1'b0);

    g = 1'b0; rv = 1'b0; word = '0;
    if (mem_busy) begin
      if (mem_cnt == 0) begin
        rv = 1'b1;
        word = mem_fn(mem_pc);
      end else mem_cnt--;
    end else if (s_req) begin
      if (gnt_wait == 0) g = 1'b1;
      else gnt_wait--;
    end
    rdy = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);

    imem_gnt = g; imem_rvalid = rv; imem_rdata = word;
    out_ready = rdy; redirect_valid = redir; redirect_pc = tgt;

    if (redir) exp_q.delete();
    else begin
      if (s_valid && rdy && exp_q.size() != 0) begin
        if (!got_pop) begin got_pop = 1'b1; first_pop_pc = exp_q[0]; end
        void'(exp_q.pop_front());
      end
      if (rv && !mem_stale) begin
        exp_q.push_back(mem_pc);
        if (stops_fetch(word)) halted_exp = 1'b1;
      end
    end
    if (rv) mem_busy = 1'b0;
    if (g) begin
      chk("imem_addr", s_addr, exp_addr);
      if (!got_gnt) begin got_gnt = 1'b1; first_gnt_addr = s_addr; end
      exp_addr += 32'd4;
      mem_busy = 1'b1; mem_pc = s_addr; mem_stale = redir;
      mem_cnt = $urandom_range(r_lo, r_hi);
      gnt_wait = $urandom_range(gnt_lo, gnt_hi);
      n_gnt++;
    end
    if (redir) begin
      if (mem_busy) mem_stale = 1'b1;
      exp_addr = {tgt[31:2], 2'b00};
      halted_exp = 1'b0;
    end
    chk("queue_bound", exp_q.size() <= DEPTH, 1'b1);
  endtask

  // Asynchronous reset mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_instr", out_instr, 32'h0);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_halted", halted, 1'b0);
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    exp_addr = 32'h2000;
    halted_exp = 1'b0;
    if (mem_busy) mem_stale = 1'b1;
    gnt_wait = $urandom_range(gnt_lo, gnt_hi);
    arm();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        ready;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
  } vec_t;

  vec_t vec[11];

  function automatic vec_t mk(input logic g, input logic rv, input logic [31:0] rd,
                              input logic er, input logic [31:0] ea, input logic ev,
                              input logic [31:0] ep, input logic [31:0] ei);
    vec_t v;
    v.gnt = g; v.rvalid = rv; v.rdata = rd; v.ready = 1'b1;
    v.exp_req = er; v.exp_addr = ea; v.exp_valid = ev; v.exp_pc = ep; v.exp_instr = ei;
    return v;
  endfunction

  initial begin
    int k;
    // Row n is sampled n cycles after reset release; inputs apply to that cycle's edge.
    vec[0]  = mk(0, 0, 32'h0,         0, 32'h0,    0, 32'h0,    32'h0);
    vec[1]  = mk(1, 0, 32'h0,         1, 32'h2000, 0, 32'h0,    32'h0);
    vec[2]  = mk(0, 1, 32'h8C00_2000, 0, 32'h0,    0, 32'h0,    32'h0);
    vec[3]  = mk(0, 0, 32'h0,         0, 32'h0,    1, 32'h2000, 32'h8C00_2000);
    vec[4]  = mk(1, 0, 32'h0,         1, 32'h2004, 0, 32'h0,    32'h0);
    vec[5]  = mk(0, 1, 32'h8C00_2004, 0, 32'h0,    0, 32'h0,    32'h0);
    vec[6]  = mk(0, 0, 32'h0,         0, 32'h0,    1, 32'h2004, 32'h8C00_2004);
    vec[7]  = mk(1, 0, 32'h0,         1, 32'h2008, 0, 32'h0,    32'h0);
    vec[8]  = mk(0, 1, 32'h8C00_2008, 0, 32'h0,    0, 32'h0,    32'h0);
    vec[9]  = mk(0, 0, 32'h0,         0, 32'h0,    1, 32'h2008, 32'h8C00_2008);
    vec[10] = mk(0, 0, 32'h0,         1, 32'h200C, 0, 32'h0,    32'h0);

    reset = 1'b1;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    exp_addr = 32'h2000; halted_exp = 1'b0;
    arm();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    for (int i = 0; i < 11; i++) begin
      chk($sformatf("vec%0d_req", i), imem_req, vec[i].exp_req);
      chk($sformatf("vec%0d_valid", i), out_valid, vec[i].exp_valid);
      chk($sformatf("vec%0d_halted", i), halted, 1'b0);
      if (vec[i].exp_req) chk($sformatf("vec%0d_addr", i), imem_addr, vec[i].exp_addr);
      if (vec[i].exp_valid || i == 0) begin
        chk($sformatf("vec%0d_pc", i), out_pc, vec[i].exp_pc);
        chk($sformatf("vec%0d_instr", i), out_instr, vec[i].exp_instr);
      end
      imem_gnt = vec[i].gnt; imem_rvalid = vec[i].rvalid; imem_rdata = vec[i].rdata;
      out_ready = vec[i].ready;
      @(negedge clk);
    end

    // Back-pressure: the queue fills to DEPTH and requests stop.
    gnt_lo = 0; gnt_hi = 0; r_lo = 0; r_hi = 0; ready_mode = 0;
    do_reset();
    repeat (20) cycle(1'b0, 32'h0);
    chk("fill_no_req", last_req, 1'b0);
    chk("fill_head_pc", last_pc, 32'h2000);
    ready_mode = 1;
    repeat (20) cycle(1'b0, 32'h0);
    chk("fill_drain_first", first_pop_pc, 32'h2000);

    // Redirect while a granted request is waiting on a slow response.
    r_lo = 3; r_hi = 3; ready_mode = 1;
    do_reset();
    k = 0;
    while (!mem_busy && k < 10) begin cycle(1'b0, 32'h0); k++; end
    chk("redir_wait_reached", mem_busy, 1'b1);
    cycle(1'b1, 32'h3002);
    arm();
    r_lo = 0; r_hi = 0;
    cycle(1'b0, 32'h0);
    chk("redir_valid_low", last_valid, 1'b0);
    repeat (20) cycle(1'b0, 32'h0);
    chk("redir_first_gnt", first_gnt_addr, 32'h3000);
    chk("redir_first_pop", first_pop_pc, 32'h3000);

    // Halt word stops fetching until a redirect.
    halt_mode = 1'b1;
    do_reset();
    k = 0;
    while (!halted_exp && k < 40) begin cycle(1'b0, 32'h0); k++; end
    chk("halt_reached", halted_exp, 1'b1);
    k = n_gnt;
    repeat (50) cycle(1'b0, 32'h0);
    chk("halt_no_grants", n_gnt - k, 0);
    halt_mode = 1'b0;
    cycle(1'b1, 32'h2000);
    arm();
    repeat (20) cycle(1'b0, 32'h0);
    chk("halt_resume_gnt", first_gnt_addr, 32'h2000);
    chk("halt_cleared", dut.halted, 1'b0);

    // Redirect coinciding with a pop and a push at two queued entries.
    ready_mode = 0;
    do_reset();
    k = 0;
    while (!(exp_q.size() == 2 && mem_busy && mem_cnt == 0) && k < 40) begin
      cycle(1'b0, 32'h0); k++;
    end
    chk("flush_setup", exp_q.size(), 2);
    ready_mode = 1;
    cycle(1'b1, 32'h4000);
    arm();
    cycle(1'b0, 32'h0);
    chk("flush_valid_low", last_valid, 1'b0);
    repeat (20) cycle(1'b0, 32'h0);
    chk("flush_first_pop", first_pop_pc, 32'h4000);

    // Reset during WAIT, then a late response arrives.
    r_lo = 3; r_hi = 3; ready_mode = 1;
    do_reset();
    k = 0;
    while (!mem_busy && k < 10) begin cycle(1'b0, 32'h0); k++; end
    chk("rst_wait_reached", mem_busy, 1'b1);
    do_reset();
    r_lo = 0; r_hi = 0;
    repeat (30) cycle(1'b0, 32'h0);
    chk("rst_first_gnt", first_gnt_addr, 32'h2000);
    chk("rst_first_pop", first_pop_pc, 32'h2000);

    // Randomized traffic.
    gnt_lo = 0; gnt_hi = 2; r_lo = 0; r_hi = 3; ready_mode = 2;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic rd;
      logic [31:0] t;
      rd = ($urandom_range(0, 39) == 0);
      t = $urandom & 32'h00FF_FFFF;
      cycle(rd, t);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tinker_fetch_unit.md
Name: tinker_fetch_unit

Overview:
Decoupled instruction-fetch stage for the Tinker core. It sits between instruction memory and decode/control. It owns the fetch PC and issues one word request at a time over a req/gnt/rvalid memory handshake. Returned words are buffered with their PCs in a small queue, and {pc, instr} pairs are presented to decode over valid/ready. Control can redirect the fetch stream on a taken branch or jump, and fetch stops after a halt instruction.

Parameters:
DEPTH, 4, entries in the instruction queue (power of 2, ≥2)
RESET_PC, 32'h2000, fetch PC after reset
OP_HALT, 5'h0F, opcode (instr[31:27]) that stops fetching

Ports:
clk  in  1  clock
reset  in  1  reset; asynchronous, active-high
redirect_valid  in  1  control redirects the fetch stream this cycle
redirect_pc  in  32  new fetch address; bits [1:0] ignored (treated as 0)
imem_req  out  1  fetch request
imem_addr  out  32  fetch word address (big-endian word, 4-byte aligned)
imem_gnt  in  1  memory accepted the request this cycle
imem_rvalid  in  1  response word valid
imem_rdata  in  32  response instruction word
out_valid  out  1  queue head is valid
out_ready  in  1  decode consumes the head this cycle
out_instr  out  32  head instruction
out_pc  out  32  PC of head instruction
halted  out  1  fetch stopped on a halt instruction

Behaviour:
- Reset (async): fetch_pc=RESET_PC, queue empty, state=IDLE, discard=0. All outputs 0: imem_req=0, imem_addr=0, out_valid=0, out_instr=0, out_pc=0, halted=0.
- States:
  - IDLE: go to REQ when queue count + in-flight < DEPTH and no redirect_valid this cycle.
  - REQ: imem_req=1, imem_addr=fetch_pc. On imem_gnt, record the in-flight PC, set fetch_pc += 4 (wraps mod 2^32) and go to WAIT.
  - WAIT: on imem_rvalid, push {pc, rdata} unless discard=1, clear discard, then go to IDLE. If the pushed word has opcode OP_HALT or equals 32'h0, go to HALTED instead.
  - HALTED: no requests; halted=1. Leave only on redirect or reset.
- One request outstanding maximum. Earliest rvalid is the cycle after gnt; rvalid is never checked outside WAIT.
- Credit rule: a request is issued only if a slot is guaranteed free, so the queue never overflows and pushes are never dropped for lack of space.
- Queue: push at the posedge on rvalid; the entry is visible on out_valid the following cycle (no bypass). Pop when out_valid & out_ready. Simultaneous push and pop are legal at any count, and count is unchanged. The head is stable while out_valid=1 and out_ready=0.
- Redirect (highest priority, effective at the posedge of the redirect_valid cycle):
  - Queue flushed; out_valid=0 the next cycle. Any same-cycle pop or push is discarded.
  - fetch_pc = {redirect_pc[31:2], 2'b00}; halted cleared; state goes to IDLE.
  - If a request is granted and unanswered (WAIT, or REQ with gnt this cycle), discard=1 and the state machine stays in WAIT until that rvalid arrives and is dropped.
  - If in REQ without gnt, the request is withdrawn. Memory samples req level-wise, so withdrawal is legal.
- From IDLE with redirect_valid low, imem_req asserts the next cycle. The fastest path from reset deassertion to first out_valid is 3 cycles with single-cycle gnt/rvalid.
- Reset mid-transaction: everything returns to the reset values immediately. A late rvalid after reset is ignored because state is IDLE.

Decomposition:
- tinker_pkg holds OP_HALT, the default RESET_PC, the fetch_state_t enum (IDLE, REQ, WAIT, HALTED) and the fetch_entry_t struct {pc[31:0], instr[31:0]}.
- Sub-module tinker_fetch_fifo: a DEPTH-entry synchronous FIFO of fetch_entry_t with push, pop, flush, count, full and empty. The fetch unit keeps the state machine, PC, credit logic and discard logic.

Test Plan:
- Reset, memory with single-cycle gnt/rvalid returning 0x8C000000 + pc, out_ready=1: imem_addr sequence 0x2000, 0x2004, 0x2008 → out_pc follows that sequence and out_instr=0x8C002000 first.
- out_ready=0 for 20 cycles: queue fills to 4 entries (0x2000–0x200C) → imem_req stays 0; on releasing out_ready, entries emerge in order with no loss or duplicate.
- Redirect to 0x3002 while WAIT with rvalid delayed 3 cycles: the stale response is dropped, the next imem_addr is 0x3000, the first out_pc is 0x3000, and out_valid=0 the cycle after redirect.
- Word 0x78000000 (opcode 0x0F) at 0x2008 → enqueued; halted=1; no further imem_req for 50 cycles; redirect to 0x2000 clears halted and resumes fetching.
- Redirect in the same cycle as pop and push at count=2 → count=0 the next cycle, neither entry is delivered, and the pushed word is discarded.
- Assert reset during WAIT, then send a late rvalid: queue stays empty, out_valid=0, and fetch restarts at 0x2000.
